// File: rtl/pulse_gen.sv
// Multi-channel pulse generator: each channel produces either a one-shot pulse
// or a periodic HIGH/LOW waveform, started by a rising edge on its trigger.
module pulse_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter bit RETRIG   = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CNT_W-1:0]    len_hi,
  input  logic [CNT_W-1:0]    len_lo,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic                rst_pulse
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // A programmed length of zero behaves as one cycle, so the counter starts at 0.
  logic [CNT_W-1:0] hi_load;
  logic [CNT_W-1:0] lo_load;
  logic             rst_pulse_q;

  assign hi_load = (len_hi == '0) ? '0 : len_hi - CNT_W'(1);
  assign lo_load = (len_lo == '0) ? '0 : len_lo - CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_pulse_q <= 1'b1;
    end else begin
      rst_pulse_q <= 1'b0;
    end
  end

  assign rst_pulse = rst_pulse_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             trig_prev_q;
    logic             trig_edge;

    assign trig_edge = trig[gi] & ~trig_prev_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      out_d   = out_q;
      done_d  = 1'b0;
      if (stop[gi]) begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (trig_edge) begin
              state_d = HIGH;
              out_d   = 1'b1;
              mode_d  = mode[gi];
              cnt_d   = hi_load;
            end
          end
          HIGH: begin
            // Retrigger wins over natural completion, so no done strobe fires.
            if (RETRIG && !mode_q && trig_edge) begin
              cnt_d = hi_load;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (mode_q) begin
              state_d = LOW;
              out_d   = 1'b0;
              cnt_d   = lo_load;
            end else begin
              state_d = IDLE;
              out_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
          LOW: begin
            if (cnt_q == '0) begin
              state_d = HIGH;
              out_d   = 1'b1;
              cnt_d   = hi_load;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            out_d   = 1'b0;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // trig_prev resets high so a trigger held through reset does not fire.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        mode_q      <= 1'b0;
        out_q       <= 1'b0;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
        trig_prev_q <= 1'b1;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        mode_q      <= mode_d;
        out_q       <= out_d;
        done_q      <= done_d;
        busy_q      <= (state_d != IDLE);
        trig_prev_q <= trig[gi];
      end
    end

    assign out[gi]  = out_q;
    assign busy[gi] = busy_q;
    assign done[gi] = done_q;
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: per-cycle expectations are queued as
// stimulus is driven and compared one clock later.
module tb_pulse_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] trig, mode, stop;
  logic [7:0] len_hi, len_lo;
  logic [3:0] out, busy, done;
  logic       rst_pulse;
  logic [3:0] out0, busy0, done0;
  logic       rst_pulse0;

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] out0;
    logic [3:0] done0;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pulse_gen #(.CHANNELS(4), .CNT_W(8), .RETRIG(1'b1)) dut (
    .clock(clock), .reset(reset), .trig(trig), .mode(mode), .stop(stop),
    .len_hi(len_hi), .len_lo(len_lo), .out(out), .busy(busy), .done(done),
    .rst_pulse(rst_pulse)
  );

  pulse_gen #(.CHANNELS(4), .CNT_W(8), .RETRIG(1'b0)) dut0 (
    .clock(clock), .reset(reset), .trig(trig), .mode(mode), .stop(stop),
    .len_hi(len_hi), .len_lo(len_lo), .out(out0), .busy(busy0), .done(done0),
    .rst_pulse(rst_pulse0)
  );

  task automatic test_reset();
    reset = 1'b1; trig = '0; mode = '0; stop = '0; len_hi = '0; len_lo = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (rst_pulse !== 1'b1) begin
      n_err++; $display("FAIL reset_rst_pulse_in_reset: got %b want 1", rst_pulse);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (rst_pulse !== 1'b1) begin
      n_err++; $display("FAIL reset_rst_pulse_before_edge: got %b want 1", rst_pulse);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_cmp++;
      if (rst_pulse !== 1'b0 || {out, busy, done} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: rst_pulse/out/busy/done=%b/%b/%b/%b want 0/0000/0000/0000",
                 c, rst_pulse, out, busy, done);
      end else $display("reset_idle cycle %0d ok", c);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    mode = 4'b0000; len_hi = 8'd5; len_lo = 8'd1;
    for (int s = 0; s <= 8; s++) begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out, busy, done} !== {e.out, e.busy, e.done}) begin
          n_err++;
          $display("FAIL oneshot step %0d: out/busy/done=%b/%b/%b want %b/%b/%b",
                   s, out, busy, done, e.out, e.busy, e.done);
        end else $display("oneshot step %0d ok out=%b done=%b", s, out, done);
      end
      if (s < 8) begin
        trig[0] = (s == 0);
        if (s == 2) len_hi = 8'd9;  // mid-phase change must not stretch the pulse
        e = '0;
        e.out[0]  = (s < 5);
        e.busy[0] = (s < 5);
        e.done[0] = (s == 5);
        sb_q.push_back(e);
      end
    end
    trig = '0;
  endtask

  task automatic test_periodic();
    exp_t e;
    mode = 4'b0010; len_hi = 8'd3; len_lo = 8'd2;
    for (int s = 0; s <= 14; s++) begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out, busy, done} !== {e.out, e.busy, e.done}) begin
          n_err++;
          $display("FAIL periodic step %0d: out/busy/done=%b/%b/%b want %b/%b/%b",
                   s, out, busy, done, e.out, e.busy, e.done);
        end else $display("periodic step %0d ok out=%b busy=%b", s, out, busy);
      end
      if (s < 14) begin
        trig[1] = (s < 3) || (s >= 4);
        trig[0] = (s == 6);
        stop[1] = (s == 11);
        e = '0;
        e.out[1]  = (s <= 10) && ((s % 5) < 3);
        e.busy[1] = (s <= 10);
        e.out[0]  = (s >= 6) && (s <= 8);
        e.busy[0] = (s >= 6) && (s <= 8);
        e.done[0] = (s == 9);
        sb_q.push_back(e);
      end
    end
    trig = '0; stop = '0;
  endtask

  task automatic test_retrig();
    exp_t e;
    mode = 4'b0000; len_hi = 8'd4;
    for (int s = 0; s <= 9; s++) begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out, done, out0, done0} !== {e.out, e.done, e.out0, e.done0}) begin
          n_err++;
          $display("FAIL retrig step %0d: out/done=%b/%b out0/done0=%b/%b want %b/%b %b/%b",
                   s, out, done, out0, done0, e.out, e.done, e.out0, e.done0);
        end else $display("retrig step %0d ok out=%b out0=%b", s, out, out0);
      end
      if (s < 9) begin
        trig[2] = (s == 0) || (s == 2);
        e = '0;
        e.out[2]   = (s <= 5);
        e.busy[2]  = (s <= 5);
        e.done[2]  = (s == 6);
        e.out0[2]  = (s <= 3);
        e.done0[2] = (s == 4);
        sb_q.push_back(e);
      end
    end
    trig = '0;
  endtask

  task automatic test_boundary();
    exp_t e;
    mode = 4'b0000; len_hi = 8'd0;
    for (int s = 0; s <= 7; s++) begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out, busy, done} !== {e.out, e.busy, e.done}) begin
          n_err++;
          $display("FAIL boundary step %0d: out/busy/done=%b/%b/%b want %b/%b/%b",
                   s, out, busy, done, e.out, e.busy, e.done);
        end else $display("boundary step %0d ok out=%b done=%b", s, out, done);
      end
      if (s < 7) begin
        trig[3] = (s == 0);
        trig[2] = (s >= 3);
        stop[2] = (s == 3);
        e = '0;
        e.out[3]  = (s == 0);
        e.busy[3] = (s == 0);
        e.done[3] = (s == 1);
        sb_q.push_back(e);
      end
    end
    trig = '0; stop = '0;
  endtask

  task automatic test_reset_mid();
    mode = 4'b0000; len_hi = 8'd10;
    @(negedge clock);
    #2 reset = 1'b1;
    trig = 4'b0001;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({out, busy, done} !== 12'h000) begin
        n_err++;
        $display("FAIL held_trig cycle %0d: out/busy/done=%b/%b/%b want 0000/0000/0000", c, out, busy, done);
      end else $display("held_trig cycle %0d ok", c);
    end
    trig = 4'b0000;
    @(negedge clock);
    trig = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (out[0] !== 1'b1 || busy[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_pulse_start: out0/busy0=%b/%b want 1/1", out[0], busy[0]);
    end else $display("mid_pulse_start ok");
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out, busy, done} !== 12'h000 || rst_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_drop: out/busy/done/rst_pulse=%b/%b/%b/%b want 0000/0000/0000/1",
               out, busy, done, rst_pulse);
    end else $display("async_reset_drop ok");
    @(negedge clock);
    reset = 1'b0; trig = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({out, busy, done} !== 12'h000) begin
        n_err++;
        $display("FAIL after_reset cycle %0d: out/busy/done=%b/%b/%b want 0000/0000/0000", c, out, busy, done);
      end else $display("after_reset cycle %0d ok", c);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_retrig();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
